row_scan_sequencer: RTL and testbench
=====================================

Name: row_scan_sequencer

Overview:
- Generates the 3-bit row select that drives the 3-to-8 decoder (sel[2]=a, sel[1]=b, sel[0]=c) for row/LED/keypad scanning.
- Steps through rows 0..7 with a programmable dwell per row and fixed blanking between rows.
- Supports per-row skip masking, plus continuous and one-shot frame modes.
- Sits directly upstream of the decoder; `active` gates the decoder output enable downstream.

Parameters:
- DWELL_W, 8, width of dwell count input.
- BLANK_CYCLES, 2, inactive cycles between consecutive rows (0 = no blanking).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, level: scan enable.
- one_shot, input, 1, 1 = stop after one frame, 0 = continuous.
- dwell, input, DWELL_W, active cycles per row; sampled on row entry; 0 treated as 1.
- skip_mask, input, 8, bit i=1 means row i is skipped; sampled at each next-row decision.
- sel, output, 3, row index to decoder (sel[2]=a, sel[1]=b, sel[0]=c).
- active, output, 1, high while the current row is in dwell.
- row_start, output, 1, one-cycle pulse on the first dwell cycle of each row.
- frame_done, output, 1, one-cycle pulse at frame completion.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at clk edge): state=IDLE, sel=0, active=0, row_start=0, frame_done=0, busy=0, dwell counter=0, done latch=0. Reset overrides all other inputs, including mid-frame.
- States: IDLE, DWELL, BLANK.
- Start condition: en=1 and done latch=0. The done latch is set when a one-shot frame completes and cleared in any cycle with en=0.
- IDLE -> DWELL on the start condition.
  - sel = lowest unmasked index.
  - Load counter with max(dwell,1).
  - active=1, row_start=1 in the first DWELL cycle, i.e. one cycle after en is sampled high.
- IDLE with skip_mask=8'hFF: remain IDLE, no pulses.
- DWELL: counter decrements each cycle; active=1 for exactly max(dwell,1) cycles.
  - On expiry, go to BLANK (active=0) if BLANK_CYCLES>0.
  - Otherwise perform the next-row decision directly.
- BLANK: active=0 for BLANK_CYCLES cycles; sel holds its value. Then perform the next-row decision.
- Next-row decision:
  - Pick the lowest unmasked index > sel.
  - If none exists, wrap to the lowest unmasked index and flag the wrap.
- On wrap:
  - frame_done=1 for one cycle, in the cycle the next frame's first row would begin.
  - Continuous mode: that cycle is also DWELL with row_start=1.
  - one_shot=1: go to IDLE instead, set the done latch, sel=0.
- All rows masked at a decision point: go IDLE with frame_done=1.
- en=0 in DWELL or BLANK (abort):
  - Next cycle: IDLE, active=0, sel=0, busy=0, no frame_done.
  - Abort takes priority over a simultaneous dwell expiry or wrap.
- skip_mask and dwell changes take effect only at the next decision or row entry; they never truncate the current row.
- Cycle math, continuous mode, mask=0: row period = max(dwell,1) + BLANK_CYCLES; frame = 8 × row period.

Decomposition:
- Shared package (scan_pkg):
  - state enum {IDLE, DWELL, BLANK}.
  - NUM_ROWS=8.
  - SEL_W=3.
- One sub-module: next_row_finder.
  - Purely combinational.
  - Inputs: cur[2:0], skip_mask[7:0].
  - Outputs: nxt[2:0], wrap, none_valid.
  - Implemented as a wrap-around priority pick.

Test Plan:
- Reset: assert rst for 3 cycles with en=1 -> sel=0, active=0, row_start=0, frame_done=0, busy=0 throughout. Repeat with rst mid-DWELL on row 4 -> all outputs return to 0 on the next edge.
- Continuous scan, dwell=2, BLANK_CYCLES=1, mask=0, en=1 sampled at cycle 0:
  - Row 0 active in cycles 1–2, blank in cycle 3.
  - Row k active in cycles 1+3k and 2+3k.
  - Row 7 active in cycles 22–23, blank in cycle 24.
  - Cycle 25: frame_done=1, row_start=1, sel=0.
- Skip mask 8'b1010_1010 -> sel sequence 0,2,4,6,0…; exactly 4 row_start pulses per frame; frame_done coincides with the return to sel=0.
- One-shot, dwell=1, BLANK_CYCLES=0, en held high:
  - Rows 0–7 in cycles 1–8.
  - Cycle 9: frame_done=1, busy=0, IDLE.
  - No restart while en stays high; en 0->1 restarts at row 0.
- Abort: drop en during row 3 dwell -> next cycle active=0, sel=0, busy=0, no frame_done pulse.
- Edge inputs:
  - dwell=0 -> active for exactly 1 cycle per row.
  - skip_mask=8'hFF with en=1 -> stays IDLE, busy=0.
  - Change mask to 8'hFF mid-frame -> at the next decision, IDLE with frame_done=1.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the row scan sequencer and its row finder.
package scan_pkg;

  localparam int NUM_ROWS = 8;
  localparam int SEL_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/next_row_finder.sv
// Wrap-around priority pick: the first unmasked row strictly after cur,
// wrapping through row 7 back to row 0. Purely combinational.
module next_row_finder
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]    cur,
  input  logic [NUM_ROWS-1:0] skip_mask,
  output logic [SEL_W-1:0]    nxt,
  output logic                wrap,
  output logic                none_valid
);

  localparam int CW = SEL_W + 1;

  logic [SEL_W:0] cand;
  logic           found;

  // The carry out of cur+i marks a pick that wrapped past row 7; i reaches
  // NUM_ROWS so that cur itself is found as a wrapped pick.
  always_comb begin
    nxt   = '0;
    wrap  = 1'b0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_ROWS; i++) begin
      cand = {1'b0, cur} + CW'(i);
      if (!found && !skip_mask[cand[SEL_W-1:0]]) begin
        found = 1'b1;
        nxt   = cand[SEL_W-1:0];
        wrap  = cand[SEL_W];
      end
    end
  end

  assign none_valid = &skip_mask;

endmodule

// File: rtl/row_scan_sequencer.sv
// Row select sequencer feeding a 3-to-8 decoder: per-row dwell, fixed
// blanking, skip masking, continuous or one-shot frames.
//
//   state | meaning
//   IDLE  | not scanning; waits for en=1 with the done latch clear
//   DWELL | current row driven, active=1, dwell counter running
//   BLANK | sel held, active=0 for BLANK_CYCLES before the next row
module row_scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                one_shot,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [NUM_ROWS-1:0] skip_mask,
  output logic [SEL_W-1:0]    sel,
  output logic                active,
  output logic                row_start,
  output logic                frame_done,
  output logic                busy
);

  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               active_q, active_d;
  logic               row_start_q, row_start_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SEL_W-1:0]   find_cur;
  logic [SEL_W-1:0]   nxt;
  logic               wrap;
  logic               none_valid;
  logic               decide;
  logic [DWELL_W-1:0] dwell_load;

  // From IDLE the search starts after the last row, yielding the lowest
  // unmasked row without a second finder.
  assign find_cur   = (state_q == IDLE) ? SEL_W'(NUM_ROWS - 1) : sel_q;
  assign dwell_load = (dwell == '0) ? DWELL_ONE : dwell;

  next_row_finder u_finder (
    .cur        (find_cur),
    .skip_mask  (skip_mask),
    .nxt        (nxt),
    .wrap       (wrap),
    .none_valid (none_valid)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    blank_d      = blank_q;
    active_d     = 1'b0;
    row_start_d  = 1'b0;
    frame_done_d = 1'b0;
    done_d       = en & done_q;
    decide       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && !done_q && !none_valid) begin
          state_d     = DWELL;
          sel_d       = nxt;
          cnt_d       = dwell_load;
          active_d    = 1'b1;
          row_start_d = 1'b1;
        end
      end
      DWELL: begin
        if (!en) begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
          blank_d = '0;
        end else if (cnt_q <= DWELL_ONE) begin
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
            blank_d = BLANK_LOAD;
            cnt_d   = '0;
          end else begin
            decide = 1'b1;
          end
        end else begin
          cnt_d    = cnt_q - DWELL_ONE;
          active_d = 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          sel_d   = '0;
          cnt_d   = '0;
          blank_d = '0;
        end else if (blank_q <= BLANK_ONE) begin
          decide = 1'b1;
        end else begin
          blank_d = blank_q - BLANK_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    // Next-row decision; a wrap in continuous mode starts the new frame in
    // the same cycle that reports the old one done.
    if (decide) begin
      if (none_valid || (wrap && one_shot)) begin
        state_d      = IDLE;
        sel_d        = '0;
        cnt_d        = '0;
        blank_d      = '0;
        frame_done_d = 1'b1;
        done_d       = !none_valid;
      end else begin
        state_d      = DWELL;
        sel_d        = nxt;
        cnt_d        = dwell_load;
        active_d     = 1'b1;
        row_start_d  = 1'b1;
        frame_done_d = wrap;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      blank_q      <= '0;
      active_q     <= 1'b0;
      row_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      blank_q      <= blank_d;
      active_q     <= active_d;
      row_start_q  <= row_start_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign sel        = sel_q;
  assign active     = active_q;
  assign row_start  = row_start_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Scoreboard bench: two sequencers (blanking 1 and 0) share stimulus; a
// row-level timeline model predicts every visible event of each.
module tb_row_scan_sequencer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, en, one_shot;
  logic [DW-1:0] dwell;
  logic [7:0]    skip_mask;

  logic [2:0] sel1, sel0;
  logic       act1, rs1, fd1, busy1;
  logic       act0, rs0, fd0, busy0;

  row_scan_sequencer #(.DWELL_W(DW), .BLANK_CYCLES(1)) u_b1 (
    .clk(clk), .rst(rst), .en(en), .one_shot(one_shot), .dwell(dwell),
    .skip_mask(skip_mask), .sel(sel1), .active(act1), .row_start(rs1),
    .frame_done(fd1), .busy(busy1)
  );

  row_scan_sequencer #(.DWELL_W(DW), .BLANK_CYCLES(0)) u_b0 (
    .clk(clk), .rst(rst), .en(en), .one_shot(one_shot), .dwell(dwell),
    .skip_mask(skip_mask), .sel(sel0), .active(act0), .row_start(rs0),
    .frame_done(fd0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  sel;
    logic        rs;
    logic        fd;
    logic        act;
    logic        busy;
  } ev_t;

  ev_t q1[$];
  ev_t q0[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  function automatic void chk_ev(string nm, ev_t g, ev_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got cyc=%0d sel=%0d rs=%0b fd=%0b act=%0b busy=%0b expected cyc=%0d sel=%0d rs=%0b fd=%0b act=%0b busy=%0b",
               nm, g.cyc, g.sel, g.rs, g.fd, g.act, g.busy,
               e.cyc, e.sel, e.rs, e.fd, e.act, e.busy);
    end
  endfunction

  function automatic ev_t mk(int c, int s, bit r, bit f, bit a, bit b);
    ev_t e;
    e.cyc  = c;
    e.sel  = s[2:0];
    e.rs   = r;
    e.fd   = f;
    e.act  = a;
    e.busy = b;
    return e;
  endfunction

  function automatic int lowest_free(logic [7:0] m);
    for (int j = 0; j < 8; j++) if (!m[j]) return j;
    return -1;
  endfunction

  function automatic int next_free(int r, logic [7:0] m);
    for (int j = r + 1; j < 8; j++) if (!m[j]) return j;
    return -1;
  endfunction

  function automatic void push(int b, ev_t e);
    if (b == 1) q1.push_back(e);
    else        q0.push_back(e);
  endfunction

  // Timeline of one enable window: a row starting at s is active for d
  // cycles, then b blank cycles, then the next row or IDLE. Mask seen by the
  // decision landing on cycle n is the one driven during cycle n-1. At cycle
  // kill everything is forced idle (en drop or reset).
  function automatic void plan(int b, int t0, int dw, logic [7:0] m0,
                               logic [7:0] m1, int tm, bit os, int kill);
    int d, s, r, e, n, nr;
    bit wr;
    logic [7:0] m;
    d = (dw == 0) ? 1 : dw;
    m = (t0 - 1 >= tm) ? m1 : m0;
    r = lowest_free(m);
    if (r < 0) return;
    s  = t0;
    wr = 1'b0;
    for (int it = 0; it < 1000; it++) begin
      if (s >= kill) begin push(b, mk(kill, 0, 0, 0, 0, 0)); return; end
      push(b, mk(s, r, 1, wr, 1, 1));
      e = s + d;
      if (b > 0) begin
        if (e >= kill) begin push(b, mk(kill, 0, 0, 0, 0, 0)); return; end
        push(b, mk(e, r, 0, 0, 0, 1));
        n = e + b;
      end else begin
        n = e;
      end
      if (n >= kill) begin push(b, mk(kill, 0, 0, 0, 0, 0)); return; end
      m  = (n - 1 >= tm) ? m1 : m0;
      nr = next_free(r, m);
      wr = 1'b0;
      if (nr < 0) begin
        nr = lowest_free(m);
        wr = 1'b1;
      end
      if (nr < 0 || (wr && os)) begin
        push(b, mk(n, 0, 0, 1, 0, 0));
        return;
      end
      r = nr;
      s = n;
    end
  endfunction

  logic p_act1 = 1'b0, p_busy1 = 1'b0, p_act0 = 1'b0, p_busy0 = 1'b0;
  ev_t  g1, e1, g0, e0;

  always @(negedge clk) begin
    if (rs1 === 1'b1 || fd1 === 1'b1 || (p_act1 && act1 !== 1'b1) ||
        (p_busy1 && busy1 !== 1'b1)) begin
      g1 = {cyc[31:0], sel1, rs1, fd1, act1, busy1};
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b1_event: unexpected event at cyc=%0d sel=%0d rs=%0b fd=%0b act=%0b busy=%0b, none expected",
                 cyc, sel1, rs1, fd1, act1, busy1);
      end else begin
        e1 = q1.pop_front();
        chk_ev("b1_event", g1, e1);
      end
    end
    p_act1  = act1;
    p_busy1 = busy1;
  end

  always @(negedge clk) begin
    if (rs0 === 1'b1 || fd0 === 1'b1 || (p_act0 && act0 !== 1'b1) ||
        (p_busy0 && busy0 !== 1'b1)) begin
      g0 = {cyc[31:0], sel0, rs0, fd0, act0, busy0};
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b0_event: unexpected event at cyc=%0d sel=%0d rs=%0b fd=%0b act=%0b busy=%0b, none expected",
                 cyc, sel0, rs0, fd0, act0, busy0);
      end else begin
        e0 = q0.pop_front();
        chk_ev("b0_event", g0, e0);
      end
    end
    p_act0  = act0;
    p_busy0 = busy0;
  end

  // Must be entered at a negedge; en is held for len sampling edges.
  task automatic run_case(int dw, logic [7:0] m0, logic [7:0] m1, int tmrel,
                          bit os, int len, bit use_rst);
    int c0, tm, kill;
    c0   = cyc;
    tm   = (tmrel > 0) ? c0 + tmrel : (1 << 30);
    kill = c0 + len + 1;
    dwell     = DW'(dw);
    skip_mask = m0;
    one_shot  = os;
    en        = 1'b1;
    plan(1, c0 + 1, dw, m0, m1, tm, os, kill);
    plan(0, c0 + 1, dw, m0, m1, tm, os, kill);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (cyc == tm) skip_mask = m1;
    end
    if (use_rst) begin
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_b1", 32'({sel1, act1, rs1, fd1, busy1}), 32'd0);
      chk("midrst_out_b0", 32'({sel0, act0, rs0, fd0, busy0}), 32'd0);
      rst = 1'b0;
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dw, len, tmrel;
    logic [7:0] m0, m1;
    bit os;

    rst       = 1'b1;
    en        = 1'b1;
    one_shot  = 1'b0;
    dwell     = DW'(2);
    skip_mask = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_b1", 32'({sel1, act1, rs1, fd1, busy1}), 32'd0);
      chk("rst_out_b0", 32'({sel0, act0, rs0, fd0, busy0}), 32'd0);
    end
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) @(negedge clk);

    run_case(2, 8'h00, 8'h00, 0, 1'b0, 55, 1'b0);
    run_case(3, 8'hAA, 8'hAA, 0, 1'b0, 45, 1'b0);
    run_case(1, 8'h00, 8'h00, 0, 1'b1, 25, 1'b0);
    run_case(1, 8'h00, 8'h00, 0, 1'b1, 25, 1'b0);
    run_case(4, 8'h00, 8'h00, 0, 1'b0, 17, 1'b0);
    run_case(0, 8'h00, 8'h00, 0, 1'b0, 20, 1'b0);

    skip_mask = 8'hFF;
    en        = 1'b1;
    repeat (6) @(negedge clk);
    chk("allmask_busy_b1", 32'(busy1), 32'd0);
    chk("allmask_busy_b0", 32'(busy0), 32'd0);
    en = 1'b0;
    repeat (2) @(negedge clk);

    run_case(3, 8'h00, 8'hFF, 5, 1'b0, 30, 1'b0);
    run_case(10, 8'h00, 8'h00, 0, 1'b0, 48, 1'b1);

    for (int t = 0; t < 12; t++) begin
      dw  = $urandom_range(0, 5);
      len = $urandom_range(10, 80);
      m0  = 8'($urandom);
      if (m0 == 8'hFF) m0 = 8'h7F;
      m1    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      tmrel = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len) : 0;
      os    = 1'($urandom_range(0, 1));
      run_case(dw, m0, m1, tmrel, os, len, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("b1_queue_drained", 32'(q1.size()), 32'd0);
    chk("b0_queue_drained", 32'(q0.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
